// File: rtl/ram_line_initiator_if.sv
// Host-side and RAM-side signal bundle for the line RAM initiator.
// master: the initiator itself. slave: the host plus the RAM it drives.
interface ram_line_initiator_if #(
    parameter int WORD_W = 32,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 4
);
    // command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    // host write word stream
    logic              wr_valid;
    logic              wr_ready;
    logic [WORD_W-1:0] wr_word;
    // host read word stream
    logic              rd_valid;
    logic              rd_ready;
    logic [WORD_W-1:0] rd_word;
    // line RAM port (combinational read)
    logic [ADDR_W-1:0] ram_addr;
    logic [LINE_W-1:0] ram_data;
    logic              ram_we;
    logic [LINE_W-1:0] ram_q;
    // command completion pulse
    logic              done;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr,
        output cmd_ready,
        input  wr_valid, wr_word,
        output wr_ready,
        output rd_valid, rd_word,
        input  rd_ready,
        output ram_addr, ram_data, ram_we,
        input  ram_q,
        output done
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr,
        input  cmd_ready,
        output wr_valid, wr_word,
        input  wr_ready,
        input  rd_valid, rd_word,
        output rd_ready,
        input  ram_addr, ram_data, ram_we,
        output ram_q,
        input  done
    );
endinterface

// File: rtl/ram_line_initiator.sv
// Line RAM initiator: packs host words into 256-bit lines for a single-cycle
// RAM write, and fetches a line and streams it back out word by word.
module ram_line_initiator #(
    parameter int WORD_W = 32,
    parameter int LINE_W = 256,
    parameter int WORDS  = 8,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    ram_line_initiator_if.master bus
);
    localparam int CNT_W = $clog2(WORDS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_reg;
    logic [LINE_W-1:0] pack;       // line being assembled during FILL
    logic [LINE_W-1:0] pack_next;
    logic [LINE_W-1:0] line_q;     // last complete line, drives ram_data
    logic [LINE_W-1:0] shift;      // captured read line, word 0 at the bottom
    logic              done_r;
    logic              last;

    assign last = (cnt == CNT_W'(WORDS - 1));

    // Drop the incoming word into its slot; the full line is taken from here
    // on the last handshake so ram_data only changes when a line is complete.
    always_comb begin
        pack_next = pack;
        for (int i = 0; i < WORDS; i++) begin
            if (cnt == CNT_W'(i)) pack_next[i*WORD_W +: WORD_W] = bus.wr_word;
        end
    end

    // Control FSM plus the pack/shift datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            addr_reg <= '0;
            pack     <= '0;
            line_q   <= '0;
            shift    <= '0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        addr_reg <= bus.cmd_addr;
                        cnt      <= '0;
                        state    <= bus.cmd_write ? S_FILL : S_READ;
                    end
                end
                S_FILL: begin
                    if (bus.wr_valid) begin
                        pack <= pack_next;
                        if (last) begin
                            line_q <= pack_next;
                            cnt    <= '0;
                            state  <= S_WRITE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    done_r <= 1'b1;
                    state  <= S_IDLE;
                end
                S_READ: begin
                    shift <= bus.ram_q;
                    cnt   <= '0;
                    state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (bus.rd_ready) begin
                        shift <= shift >> WORD_W;
                        if (last) begin
                            cnt    <= '0;
                            done_r <= 1'b1;
                            state  <= S_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.wr_ready  = (state == S_FILL);
    assign bus.rd_valid  = (state == S_DRAIN);
    assign bus.rd_word   = shift[WORD_W-1:0];
    assign bus.ram_addr  = addr_reg;
    assign bus.ram_data  = line_q;
    assign bus.ram_we    = (state == S_WRITE);
    assign bus.done      = done_r;
endmodule
